pipeline_controller: RTL
========================

// Module: pipeline_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Collects stall requests from IF/ID/EX/MEM
//  and exception requests from MEM; drives per-latch hold controls, the flush pulse and the redirect PC.
//  Sits beside the pc register and the if_id/id_ex/ex_mem/mem_wb latches; every latch obeys its outputs.
// PARAMETERS
//  WATCHDOG_CYCLES  1024  consecutive stall cycles after which stall_timeout is raised (>=2)
//  COUNTER_WIDTH    32    width of the saturating stall-cycle performance counter
// PORTS
//  clock                 input   1   rising-edge clock
//  reset                 input   1   synchronous, active-high
//  if_stall_request      input   1   fetch waiting on instruction memory
//  id_stall_request      input   1   load-use hazard detected in decode
//  ex_stall_request      input   1   multi-cycle mult/div busy (HI/LO not ready)
//  mem_stall_request     input   1   data memory access in flight; cannot be aborted
//  exception_request     input   1   MEM stage reports exception (level, held until accepted)
//  exception_address     input   32  handler entry address, valid with exception_request
//  exception_accept      output  1   one-cycle pulse: exception taken this cycle
//  stall                 output  5   [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb: 1 = hold
//  flush                 output  1   one-cycle: all latches load bubble (write enables cleared)
//  redirect_enable       output  1   one-cycle: pc loads redirect_address
//  redirect_address      output  32  new PC, valid with redirect_enable
//  stall_timeout         output  1   sticky: stall exceeded WATCHDOG_CYCLES
//  stall_cycle_count     output  CW  saturating count of cycles with any stall bit set
// BEHAVIOUR
//  Reset: stall=0, flush=0, redirect_enable=0, redirect_address=0, exception_accept=0,
//   stall_timeout=0, stall_cycle_count=0, state=RUN; reset mid-PENDING discards the exception.
//  Stall decode (combinational from requests, registered state only gates it):
//   mem -> 5'b01111; ex -> 5'b00111; id -> 5'b00011; if -> 5'b00001; none -> 0. Deepest stage wins.
//   Latch k held while latch k+1 not held => latch k+1 loads a bubble (write enables cleared).
//  States:
//   RUN: no exception -> drive stall decode. exception_request && !mem_stall_request -> FLUSH
//        actions this cycle: flush=1, redirect_enable=1, redirect_address=exception_address,
//        exception_accept=1, stall=0. exception_request && mem_stall_request -> PENDING.
//   PENDING: stall=5'b01111 (hold pipeline, let memory finish); flush=0. When mem_stall_request
//        drops: same flush/redirect/accept pulse as above in that cycle, next state RUN.
//   Flush overrides all stall requests in the cycle it fires. All pulses last exactly one cycle;
//   exception_request must deassert the cycle after exception_accept (producer contract).
//  Latency: flush/redirect are registered -> visible the cycle after the qualifying request edge;
//   stall is combinational from requests (zero-cycle) so the latches hold in the same cycle.
//  Watchdog: counter of consecutive cycles with stall!=0; clears when stall==0 or flush;
//   reaching WATCHDOG_CYCLES sets stall_timeout (sticky until reset); counter saturates, no wrap.
//  stall_cycle_count: +1 each cycle stall!=0 (PENDING included); saturates at all-ones.
//  Simultaneous: exception + id/ex/if stall in RUN -> flush wins; exception + mem stall -> PENDING.
// STRUCTURE
//  Shared package/defines: STALL_* bit indices, STALL_MEM/EX/ID/IF vectors, state encoding
//   (RUN, PENDING), RESET_ENABLE / WRITE_DISABLE levels shared with the latch modules.
//  One sub-module: stall_watchdog (consecutive counter + sticky timeout + saturating perf counter).
//  FSM, stall decode and redirect register live in pipeline_controller itself.
// TESTING
//  1 id_stall_request=1 for 3 cycles -> stall=5'b00011 those cycles, id_ex gets bubbles, count=3.
//  2 ex_stall_request and id_stall_request together -> stall=5'b00111 (deepest wins).
//  3 exception_request, address 32'h0000_0380, no mem stall -> next cycle flush=1,
//    redirect_enable=1, redirect_address=32'h380, exception_accept=1, stall=0, all one cycle.
//  4 exception while mem_stall_request held 4 cycles -> PENDING, stall=5'b01111 for 4 cycles,
//    flush/accept in the cycle after mem stall drops; no flush earlier.
//  5 WATCHDOG_CYCLES=8, if_stall_request held 10 cycles -> stall_timeout rises at cycle 8, stays 1
//    after request drops; reset clears it and stall_cycle_count.
//  6 reset asserted during PENDING -> all outputs zero next cycle, exception not accepted afterward.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and the pipeline latches.
//  - STALL_* bit indices into the 5-bit hold vector (pc, if_id, id_ex, ex_mem, mem_wb)
//  - STALL_MEM/EX/ID/IF hold vectors; a deeper stage also holds every latch in front of it
//  - controller state encoding (RUN, PENDING)
//  - RESET_ENABLE / WRITE_DISABLE levels used by the latch modules
package pipeline_controller_pkg;

    localparam int STALL_W      = 5;
    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;

    localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;
    localparam logic [STALL_W-1:0] STALL_IF   = 5'b00001;
    localparam logic [STALL_W-1:0] STALL_ID   = 5'b00011;
    localparam logic [STALL_W-1:0] STALL_EX   = 5'b00111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 5'b01111;

    localparam logic RESET_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } controller_state_t;

    // Deepest requesting stage wins; its vector already covers the shallower ones.
    function automatic logic [STALL_W-1:0] stall_decode(
        input logic if_req,
        input logic id_req,
        input logic ex_req,
        input logic mem_req
    );
        if (mem_req)     return STALL_MEM;
        else if (ex_req) return STALL_EX;
        else if (id_req) return STALL_ID;
        else if (if_req) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipeline_controller_stall_watchdog.sv
// stall_watchdog: consecutive-stall watchdog plus saturating stall-cycle perf counter.
// Ports:
//  clock, reset          rising-edge clock, synchronous active-high reset
//  stall_active          any hold bit set this cycle
//  flush                 flush pulse this cycle (restarts the consecutive count)
//  stall_timeout         sticky, set once WATCHDOG_CYCLES consecutive stall cycles are seen
//  stall_cycle_count     saturating count of cycles with stall_active
module stall_watchdog #(
    parameter int WATCHDOG_CYCLES = 1024,
    parameter int COUNTER_WIDTH   = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall_active,
    input  logic                     flush,
    output logic                     stall_timeout,
    output logic [COUNTER_WIDTH-1:0] stall_cycle_count
);

    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_CYCLES);

    logic [WD_W-1:0] run_count;
    logic            counting;

    assign counting = stall_active && !flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            run_count         <= '0;
            stall_timeout     <= 1'b0;
            stall_cycle_count <= '0;
        end else begin
            // Consecutive counter parks at the limit instead of wrapping.
            if (!counting)
                run_count <= '0;
            else if (run_count != WD_LIMIT)
                run_count <= run_count + WD_W'(1);

            // This cycle is stall number run_count+1; timeout lands when that reaches the limit.
            if (counting && run_count >= WD_LIMIT - WD_W'(1))
                stall_timeout <= 1'b1;

            if (stall_active && stall_cycle_count != '1)
                stall_cycle_count <= stall_cycle_count + COUNTER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush sequencer for the 5-stage pipeline.
// Ports:
//  clock, reset                      rising-edge clock, synchronous active-high reset
//  if/id/ex/mem_stall_request        per-stage stall requests
//  exception_request/_address        MEM-stage exception (level) and handler entry address
//  exception_accept                  one-cycle pulse, exception taken
//  stall[4:0]                        hold per latch ([0]pc .. [4]mem_wb), combinational
//  flush, redirect_enable            one-cycle registered pulses
//  redirect_address                  new PC, valid with redirect_enable
//  stall_timeout, stall_cycle_count  watchdog and perf counter
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int WATCHDOG_CYCLES = 1024,
    parameter int COUNTER_WIDTH   = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     if_stall_request,
    input  logic                     id_stall_request,
    input  logic                     ex_stall_request,
    input  logic                     mem_stall_request,
    input  logic                     exception_request,
    input  logic [31:0]              exception_address,
    output logic                     exception_accept,
    output logic [STALL_W-1:0]       stall,
    output logic                     flush,
    output logic                     redirect_enable,
    output logic [31:0]              redirect_address,
    output logic                     stall_timeout,
    output logic [COUNTER_WIDTH-1:0] stall_cycle_count
);

    controller_state_t state;
    logic              take_exception;

    // The producer still holds exception_request during the accept cycle, so
    // nothing is taken while the accept pulse is out.
    always_comb begin
        take_exception = 1'b0;
        stall          = STALL_NONE;
        if (!exception_accept) begin
            if (state == PENDING)
                take_exception = !mem_stall_request;
            else
                take_exception = exception_request && !mem_stall_request;
        end
        // A pending or firing flush overrides every stall request.
        if (!flush && !take_exception) begin
            if (state == PENDING)
                stall = STALL_MEM;
            else
                stall = stall_decode(if_stall_request, id_stall_request,
                                     ex_stall_request, mem_stall_request);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= RUN;
            flush            <= 1'b0;
            redirect_enable  <= 1'b0;
            exception_accept <= 1'b0;
            redirect_address <= '0;
        end else begin
            flush            <= take_exception;
            redirect_enable  <= take_exception;
            exception_accept <= take_exception;
            if (take_exception)
                redirect_address <= exception_address;

            case (state)
                RUN:
                    if (exception_request && mem_stall_request && !exception_accept)
                        state <= PENDING;
                PENDING:
                    if (!mem_stall_request)
                        state <= RUN;
                default:
                    state <= RUN;
            endcase
        end
    end

    stall_watchdog #(
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES),
        .COUNTER_WIDTH   (COUNTER_WIDTH)
    ) u_watchdog (
        .clock             (clock),
        .reset             (reset),
        .stall_active      (|stall),
        .flush             (flush),
        .stall_timeout     (stall_timeout),
        .stall_cycle_count (stall_cycle_count)
    );

endmodule
